apb_txn_capture: RTL and testbench
==================================

Name: apb_txn_capture

Overview:
- Parametrised passive APB transfer capture unit. Snoops a completer-side APB bus, reconstructs each completed transfer with its wait-state count and error status, and queues the records in a FIFO for a downstream consumer (trace/scoreboard logic).
- Generalises the single-shot monitor:
  - parametrised address/data widths;
  - buffers records at any depth without losing back-to-back transfers;
  - counts wait states instead of reporting zero;
  - flags protocol violations and overflow drops.

Parameters:
- ADDR_W, 32, paddr and record address width.
- DATA_W, 32, pwdata/prdata and record data width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- DLY_W, 8, wait-state counter width; saturating.
- CNT_W, 8, drop counter width; saturating.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- psel  in  1  APB select (snooped).
- penable  in  1  APB enable (snooped).
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  ADDR_W  APB address.
- pwdata  in  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.
- txn_valid  out  1  FIFO head holds a record.
- txn_ready  in  1  consumer pops head when txn_valid & txn_ready.
- txn_addr  out  ADDR_W  record address.
- txn_rw  out  1  record direction, 1 = write.
- txn_wdata  out  DATA_W  pwdata for writes, 0 for reads.
- txn_rdata  out  DATA_W  prdata for reads, 0 for writes.
- txn_delay  out  DLY_W  wait states (ACCESS edges with pready = 0).
- txn_slverr  out  1  pslverr sampled at completion.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky; a record was dropped.
- drop_cnt  out  CNT_W  dropped records, saturating.
- proto_err  out  1  sticky; protocol violation seen.
- clr  in  1  synchronous clear of overflow, drop_cnt, proto_err.

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE and the FIFO is emptied.
  - All outputs are 0: txn_valid, fifo_count, overflow, drop_cnt, proto_err and all txn_* fields.
  - Reset mid-transfer discards the in-flight transfer; the bus is then resynchronised at the next setup phase.
- FSM, evaluated at each rising edge:
  - IDLE: psel & !penable -> latch paddr, pwrite, pwdata; clear dly; go to ACCESS. psel & penable -> proto_err = 1; stay in IDLE.
  - ACCESS, psel & penable & pready: complete. Build the record, attempt a push, go to IDLE.
  - ACCESS, psel & penable & !pready: dly = min(dly + 1, 2^DLY_W - 1); stay in ACCESS.
  - ACCESS, paddr or pwrite differs from the latched value while psel & penable: proto_err = 1. The transfer still completes normally with the latched values.
  - ACCESS, !psel or !penable: proto_err = 1; abandon the transfer without a push. If psel & !penable, treat this edge as a new setup (re-latch, stay in ACCESS); otherwise go to IDLE.
- Record contents: rdata is taken from prdata at the completion edge. Zero-wait transfer -> delay 0.
- Back-to-back transfers: a setup on the edge after completion is captured. Minimum 2 cycles per transfer; no loss.
- FIFO behaviour:
  - Registered and first-word-fall-through. A push at edge N gives txn_valid = 1 after edge N.
  - Head fields hold steady while txn_valid & !txn_ready.
  - Pop when txn_valid & txn_ready.
- Full FIFO:
  - A push succeeds if the FIFO is not full, or if a pop happens on the same edge.
  - Otherwise the record is dropped: overflow = 1 and drop_cnt increments, saturating at 2^CNT_W - 1.
- Empty FIFO: a push and txn_ready on the same edge leave the record queued; no bypass.
- fifo_count = pushes - pops and is always in the range 0..DEPTH.
- clr: clears the sticky flags and drop_cnt. If an error event lands on the same edge as clr, the event wins and the flag/count is 1.
- Pointers wrap modulo DEPTH.

Test Plan:
- Write 0xA5A5_0001 to 0x40, pready high in the first access cycle -> one record: rw = 1, addr 0x40, wdata 0xA5A5_0001, rdata 0, delay 0, slverr 0; txn_valid rises one cycle after completion.
- Read from 0x80 with pready low for 3 ACCESS cycles, prdata 0xDEAD_BEEF, pslverr = 1 at completion -> delay 3, rdata 0xDEAD_BEEF, slverr 1.
- DEPTH = 4, txn_ready = 0, 6 back-to-back writes -> fifo_count 4, overflow = 1, drop_cnt 2; draining returns the first 4 records in order.
- Full FIFO with txn_ready = 1 on the completion edge -> push accepted, fifo_count stays 4, drop_cnt unchanged.
- penable high without a prior setup, and separately psel dropped mid-ACCESS -> proto_err = 1, no record pushed; clr clears proto_err, and the next transfer is captured correctly.
- DLY_W = 2, 6 wait states -> delay 3 (saturated). Assert rst_n low mid-ACCESS -> FIFO empty, all outputs 0, next transfer captured.

Source files
------------

// File: rtl/apb_txn_capture.sv
// apb_txn_capture
//   Passive APB completer-side snooper. Rebuilds every completed transfer
//   (address, direction, data, wait-state count, slave error) and queues the
//   records in a first-word-fall-through FIFO for a downstream consumer.
//   Protocol violations and records dropped on a full FIFO are flagged.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   psel, penable, pwrite : snooped APB control
//   paddr, pwdata, prdata : snooped APB address / write data / read data
//   pready, pslverr       : snooped APB completion handshake
//   txn_valid, txn_ready  : record stream handshake (pop on valid & ready)
//   txn_addr .. txn_slverr: fields of the record at the FIFO head
//   fifo_count            : FIFO occupancy, 0..DEPTH
//   overflow, drop_cnt    : sticky drop flag and saturating drop counter
//   proto_err             : sticky protocol violation flag
//   clr                   : synchronous clear of overflow, drop_cnt, proto_err
module apb_txn_capture #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int DLY_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic                     txn_valid,
  input  logic                     txn_ready,
  output logic [ADDR_W-1:0]        txn_addr,
  output logic                     txn_rw,
  output logic [DATA_W-1:0]        txn_wdata,
  output logic [DATA_W-1:0]        txn_rdata,
  output logic [DLY_W-1:0]         txn_delay,
  output logic                     txn_slverr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     proto_err,
  input  logic                     clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic [DATA_W-1:0]   r_wdata;
  logic [DLY_W-1:0]    r_dly;

  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic [ADDR_W-1:0]   r_mem_addr   [DEPTH];
  logic                r_mem_rw     [DEPTH];
  logic [DATA_W-1:0]   r_mem_wdata  [DEPTH];
  logic [DATA_W-1:0]   r_mem_rdata  [DEPTH];
  logic [DLY_W-1:0]    r_mem_delay  [DEPTH];
  logic                r_mem_slverr [DEPTH];

  logic                r_overflow;
  logic [CNT_W-1:0]    r_drop_cnt;
  logic                r_proto_err;

  logic                w_busy;
  logic                w_setup;
  logic                w_in_access;
  logic                w_complete;
  logic                w_mismatch;
  logic                w_proto_evt;
  logic                w_full;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_drop;

  assign w_busy      = psel & penable;
  assign w_setup     = psel & ~penable;
  assign w_in_access = (r_state == S_ACCESS);
  assign w_complete  = w_in_access & w_busy & pready;

  // Address/direction must stay stable across the access phase.
  assign w_mismatch  = w_in_access & w_busy & ((paddr != r_addr) | (pwrite != r_rw));

  // Violations: enable without a setup, unstable access phase, or an access
  // phase that was abandoned before completion.
  assign w_proto_evt = (~w_in_access & w_busy) | w_mismatch | (w_in_access & ~w_busy);

  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = (r_count != '0) & txn_ready;
  // A pop on the same edge frees the slot a full FIFO needs for this push.
  assign w_push_ok = w_complete & (~w_full | w_pop);
  assign w_drop    = w_complete & ~w_push_ok;

  // Bus-phase tracker. A setup seen while already in ACCESS abandons the old
  // transfer and restarts from the new setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_dly   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_addr  <= paddr;
            r_rw    <= pwrite;
            r_wdata <= pwdata;
            r_dly   <= '0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_busy) begin
            if (pready) begin
              r_state <= S_IDLE;
            end else if (r_dly != '1) begin
              r_dly <= r_dly + 1'b1;
            end
          end else if (w_setup) begin
            r_addr  <= paddr;
            r_rw    <= pwrite;
            r_wdata <= pwdata;
            r_dly   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Record storage; contents are only observable through the valid mask.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_addr[r_wr_ptr]   <= r_addr;
      r_mem_rw[r_wr_ptr]     <= r_rw;
      r_mem_wdata[r_wr_ptr]  <= r_rw ? r_wdata : '0;
      r_mem_rdata[r_wr_ptr]  <= r_rw ? '0 : prdata;
      r_mem_delay[r_wr_ptr]  <= r_dly;
      r_mem_slverr[r_wr_ptr] <= pslverr;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky status; an event on the same edge as clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow & ~clr) | w_drop;
      r_proto_err <= (r_proto_err & ~clr) | w_proto_evt;
      if (clr) begin
        r_drop_cnt <= CNT_W'(w_drop);
      end else if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign txn_valid  = (r_count != '0);
  assign fifo_count = r_count;
  assign txn_addr   = txn_valid ? r_mem_addr[r_rd_ptr]   : '0;
  assign txn_rw     = txn_valid ? r_mem_rw[r_rd_ptr]     : 1'b0;
  assign txn_wdata  = txn_valid ? r_mem_wdata[r_rd_ptr]  : '0;
  assign txn_rdata  = txn_valid ? r_mem_rdata[r_rd_ptr]  : '0;
  assign txn_delay  = txn_valid ? r_mem_delay[r_rd_ptr]  : '0;
  assign txn_slverr = txn_valid ? r_mem_slverr[r_rd_ptr] : 1'b0;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_apb_txn_capture.sv
// tb_apb_txn_capture
//   Drives APB transfers into apb_txn_capture and compares every cycle
//   against a queue-based model of the record stream and status flags.
module tb_apb_txn_capture;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int DLY_W   = 2;
  localparam int CNT_W   = 3;
  localparam int DLY_MAX = 3;
  localparam int CNT_MAX = 7;

  logic                   clk;
  logic                   rst_n;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic [DATA_W-1:0]      prdata;
  logic                   pready;
  logic                   pslverr;
  logic                   txn_valid;
  logic                   txn_ready;
  logic [ADDR_W-1:0]      txn_addr;
  logic                   txn_rw;
  logic [DATA_W-1:0]      txn_wdata;
  logic [DATA_W-1:0]      txn_rdata;
  logic [DLY_W-1:0]       txn_delay;
  logic                   txn_slverr;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic [CNT_W-1:0]       drop_cnt;
  logic                   proto_err;
  logic                   clr;

  apb_txn_capture #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DLY_W(DLY_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .txn_valid(txn_valid), .txn_ready(txn_ready),
    .txn_addr(txn_addr), .txn_rw(txn_rw), .txn_wdata(txn_wdata),
    .txn_rdata(txn_rdata), .txn_delay(txn_delay), .txn_slverr(txn_slverr),
    .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt),
    .proto_err(proto_err), .clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DLY_W-1:0]  delay;
    logic              slverr;
  } rec_t;

  typedef struct {
    bit                write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                waits;
    bit                slverr;
    int                expDelay;
    bit                readyAtEnd;
    bit                badAddr;
  } vec_t;

  rec_t q[$];
  bit   mOvf;
  int   mDrops;
  bit   mPerr;
  bit   evComplete;
  bit   evProto;
  rec_t evRec;
  bit   randReady;
  int   nTests;
  int   nFail;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("txn_valid", txn_valid, q.size() != 0);
    check("fifo_count", fifo_count, q.size());
    check("overflow", overflow, mOvf);
    check("drop_cnt", drop_cnt, mDrops);
    check("proto_err", proto_err, mPerr);
    if (q.size() > 0) begin
      check("txn_addr", txn_addr, q[0].addr);
      check("txn_rw", txn_rw, q[0].rw);
      check("txn_wdata", txn_wdata, q[0].wdata);
      check("txn_rdata", txn_rdata, q[0].rdata);
      check("txn_delay", txn_delay, q[0].delay);
      check("txn_slverr", txn_slverr, q[0].slverr);
    end else begin
      check("txn_addr_idle", txn_addr, 0);
      check("txn_wdata_idle", txn_wdata, 0);
      check("txn_rdata_idle", txn_rdata, 0);
      check("txn_delay_idle", txn_delay, 0);
    end
  endtask

  // One clock: the model applies the spec rules for the edge, then outputs
  // are compared on the following falling edge.
  task automatic step();
    bit pop;
    bit c;
    if (randReady) txn_ready = 1'($urandom_range(0, 1));
    pop = txn_ready && (q.size() > 0);
    c = clr;
    @(posedge clk);
    if (c) begin
      mOvf = 0;
      mDrops = 0;
      mPerr = 0;
    end
    if (pop) void'(q.pop_front());
    if (evComplete) begin
      if (q.size() < DEPTH) q.push_back(evRec);
      else begin
        mOvf = 1;
        if (mDrops < CNT_MAX) mDrops++;
      end
    end
    if (evProto) mPerr = 1;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleSteps(input int n);
    psel = 0;
    penable = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic vec_t mkVec(input bit w, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input int waits,
                                 input bit err, input int expDly);
    vec_t v;
    v.write = w; v.addr = a; v.data = d; v.waits = waits; v.slverr = err;
    v.expDelay = expDly; v.readyAtEnd = 0; v.badAddr = 0;
    return v;
  endfunction

  // Full setup/access/complete sequence for one transfer.
  task automatic applyStimulus(input vec_t v);
    psel = 1; penable = 0; pwrite = v.write; paddr = v.addr;
    pwdata = v.write ? v.data : $urandom;
    prdata = $urandom; pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1));
    evComplete = 0; evProto = 0;
    step();
    penable = 1; pready = 0;
    if (v.badAddr) begin
      paddr = v.addr ^ 16'h0004;
      evProto = 1;
    end
    for (int i = 0; i < v.waits; i++) begin
      pwdata = $urandom; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      step();
    end
    pwdata = $urandom; pready = 1; pslverr = v.slverr;
    prdata = v.write ? $urandom : v.data;
    evComplete = 1;
    evRec.addr   = v.addr;
    evRec.rw     = v.write;
    evRec.wdata  = v.write ? v.data : '0;
    evRec.rdata  = v.write ? '0 : v.data;
    evRec.delay  = DLY_W'(v.expDelay);
    evRec.slverr = v.slverr;
    if (v.readyAtEnd) txn_ready = 1;
    step();
    evComplete = 0; evProto = 0;
    if (v.readyAtEnd) txn_ready = 0;
    psel = 0; penable = 0; pready = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 0;
    psel = 0; penable = 0; pready = 0; evComplete = 0; evProto = 0;
    #1;
    q.delete();
    mOvf = 0; mDrops = 0; mPerr = 0;
    checkOutput();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    vec_t v;
    nTests = 0; nFail = 0;
    mOvf = 0; mDrops = 0; mPerr = 0; evComplete = 0; evProto = 0; randReady = 0;
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    prdata = '0; pready = 0; pslverr = 0; txn_ready = 0; clr = 0;
    @(negedge clk);
    checkOutput();
    rst_n = 1;
    idleSteps(2);

    // Directed transfer table; expected delay is part of each record.
    tbl[0] = mkVec(1, 16'h0040, 32'hA5A5_0001, 0, 0, 0);
    tbl[1] = mkVec(0, 16'h0080, 32'hDEAD_BEEF, 3, 1, 3);
    tbl[2] = mkVec(1, 16'h1234, 32'h0102_0304, 6, 0, 3);
    tbl[3] = mkVec(0, 16'h00FC, 32'h0BAD_F00D, 1, 0, 1);
    tbl[4] = mkVec(1, 16'hFFFC, 32'hFFFF_FFFF, 2, 1, 2);
    tbl[5] = mkVec(0, 16'h0100, 32'h5555_AAAA, 1, 0, 1);
    tbl[5].badAddr = 1;
    txn_ready = 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i]);
      idleSteps(i % 2);
    end
    idleSteps(2);
    check("perr_addr_change", proto_err, 1);
    clr = 1; step(); clr = 0; step();

    // Overflow: six back-to-back writes into a stalled 4-deep FIFO.
    txn_ready = 0;
    for (int i = 0; i < 6; i++)
      applyStimulus(mkVec(1, 16'h0200 + 16'(i * 4), 32'h1000 + i, 0, 0, 0));
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_cnt, 2);
    v = mkVec(0, 16'h0300, 32'hCAFE_0007, 1, 0, 1);
    v.readyAtEnd = 1;
    applyStimulus(v);
    check("full_pop_push_count", fifo_count, 4);
    check("full_pop_push_drops", drop_cnt, 2);
    txn_ready = 1;
    idleSteps(5);
    check("drained", fifo_count, 0);
    clr = 1; step(); clr = 0;

    // Enable without setup.
    psel = 1; penable = 1; evProto = 1; step(); evProto = 0;
    idleSteps(1);
    check("perr_nosetup", proto_err, 1);
    check("perr_nosetup_count", fifo_count, 0);
    clr = 1; step(); clr = 0; step();
    check("perr_cleared", proto_err, 0);

    // psel dropped in the middle of an access phase.
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h0500; pwdata = 32'h1111_2222; step();
    penable = 1; pready = 0; step();
    psel = 0; penable = 0; evProto = 1; step(); evProto = 0;
    idleSteps(1);
    check("perr_abandon", proto_err, 1);
    // Clear and a fresh violation on the same edge: the violation wins.
    psel = 1; penable = 1; clr = 1; evProto = 1; step();
    clr = 0; evProto = 0;
    idleSteps(1);
    check("perr_clr_race", proto_err, 1);
    clr = 1; step(); clr = 0;
    applyStimulus(mkVec(0, 16'h0600, 32'h7777_8888, 0, 0, 0));
    idleSteps(1);

    // Fresh setup during ACCESS restarts the transfer with the new values.
    psel = 1; penable = 0; pwrite = 0; paddr = 16'h0700; step();
    penable = 1; pready = 0; step();
    penable = 0; pwrite = 1; paddr = 16'h0704; pwdata = 32'h4242_4242; evProto = 1; step();
    evProto = 0; penable = 1; pready = 0; pwdata = 32'h0; step();
    pready = 1; evComplete = 1;
    evRec.addr = 16'h0704; evRec.rw = 1; evRec.wdata = 32'h4242_4242; evRec.rdata = '0;
    evRec.delay = 2'd1; evRec.slverr = 0; pslverr = 0;
    step();
    evComplete = 0;
    idleSteps(3);
    clr = 1; step(); clr = 0;

    // Reset in the middle of ACCESS with records queued and a sticky flag set.
    txn_ready = 0;
    applyStimulus(mkVec(1, 16'h0800, 32'hAAAA_0001, 0, 0, 0));
    applyStimulus(mkVec(0, 16'h0804, 32'hAAAA_0002, 1, 1, 1));
    psel = 1; penable = 1; evProto = 1; step(); evProto = 0;
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h0808; step();
    penable = 1; pready = 0; step(); step();
    doReset();
    check("rst_count", fifo_count, 0);
    check("rst_perr", proto_err, 0);
    txn_ready = 1;
    idleSteps(1);
    applyStimulus(mkVec(1, 16'h0900, 32'hBEEF_0009, 2, 0, 2));
    idleSteps(2);

    // Randomized traffic with a randomly stalling consumer.
    randReady = 1;
    for (int n = 0; n < 150; n++) begin
      int gap;
      int waits;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) begin
          psel = 1; penable = 1; evProto = 1;
        end else begin
          psel = 0; penable = 0;
        end
        step();
        clr = 0; evProto = 0; psel = 0; penable = 0;
      end
      waits = $urandom_range(0, 5);
      v = mkVec(1'($urandom_range(0, 1)), 16'($urandom), $urandom, waits,
                1'($urandom_range(0, 1)), (waits > DLY_MAX) ? DLY_MAX : waits);
      v.badAddr = ($urandom_range(0, 15) == 0);
      applyStimulus(v);
    end
    randReady = 0;
    txn_ready = 1;
    idleSteps(DEPTH + 2);
    check("final_empty", txn_valid, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
